// File: rtl/bcd_stopwatch_counter.sv
// BCD stopwatch MM:SS.hh counter with a 4-digit multiplexed active-low 7-segment driver.
// Latency: count updates on the clk edge that first samples slow_clk high; an/seg/dp lag the scan index by 1 cycle.
// Backpressure: none; ticks arrive only while slow_clk toggles, so pausing the generator holds the count.
module bcd_stopwatch_counter #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slow_clk,
    input  logic        clr,
    output logic [23:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic          slow_q;
    logic          tick;
    logic [23:0]   count_next;
    logic          roll;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [15:0]   disp;
    logic [3:0]    cur_digit;

    // Digit order inside count_bcd is H0,H1,S0,S1,M0,M1 from the LSB up; tens of seconds/minutes stop at 5.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick = slow_clk & ~slow_q;

    always_comb begin
        count_next = count_bcd;
        roll       = 1'b0;
        if (tick) begin
            roll = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (roll) begin
                    if (count_bcd[i*4 +: 4] >= digit_max(i)) begin
                        count_next[i*4 +: 4] = 4'd0;
                    end else begin
                        count_next[i*4 +: 4] = count_bcd[i*4 +: 4] + 4'd1;
                        roll = 1'b0;
                    end
                end
            end
        end
    end

    // Seconds/hundredths view until the first minute elapses, then minutes/seconds.
    assign disp      = (count_bcd[23:16] == 8'h00) ? count_bcd[15:0] : count_bcd[23:8];
    assign cur_digit = disp[scan_idx*4 +: 4];

    always_ff @(posedge clk) begin
        slow_q <= slow_clk;
        if (!reset_n) begin
            count_bcd   <= '0;
            wrap        <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            scan_idx    <= 2'd0;
            refresh_cnt <= '0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count_bcd <= '0;
            end else if (tick) begin
                count_bcd <= count_next;
                wrap      <= roll;
            end

            if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_code(cur_digit);
            dp  <= (scan_idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Randomised self-checking bench for bcd_stopwatch_counter against an elapsed-hundredths model.
module tb_bcd_stopwatch_counter;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        slow_clk = 1'b0;
    logic        clr = 1'b0;
    logic [23:0] count_bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    bcd_stopwatch_counter #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .slow_clk(slow_clk), .clr(clr),
        .count_bcd(count_bcd), .wrap(wrap), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;
    int          t_before = 0;
    logic        prev_s = 1'b0;
    logic        wrap_exp = 1'b0;
    int          cyc = 0;
    logic [23:0] pre_val;
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Posedges since reset release; the scan position is a pure function of this.
    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [23:0] to_bcd(input int v);
        int m, s, h;
        m = v / 6000;
        s = (v / 100) % 60;
        h = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    function automatic logic [15:0] disp_digits(input int v);
        int m, s, h;
        m = v / 6000;
        s = (v / 100) % 60;
        h = v % 100;
        if (m == 0) return {4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int exp_idx(input int c);
        return ((c - 1) / DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_an(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << exp_idx(c));
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int c);
        logic [15:0] dd;
        logic [3:0]  d;
        dd = disp_digits(v);
        d  = dd[exp_idx(c)*4 +: 4];
        return seg_tab[d];
    endfunction

    // Drive inputs at a negedge, advance the model across the posedge, return at the next negedge.
    task automatic step(input logic s, input logic c);
        slow_clk = s;
        clr      = c;
        @(posedge clk);
        t_before = t;
        wrap_exp = 1'b0;
        if (c) begin
            t = 0;
        end else if (s && !prev_s) begin
            if (t == 359999) begin
                t = 0;
                wrap_exp = 1'b1;
            end else begin
                t = t + 1;
            end
        end
        prev_s = s;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        clr      = 1'b0;
        repeat (3) @(negedge clk);
        t = 0;
        t_before = 0;
        wrap_exp = 1'b0;
        prev_s = slow_clk;
        reset_n = 1'b1;
    endtask

    task automatic preload(input int v);
        pre_val  = to_bcd(v);
        slow_clk = 1'b0;
        clr      = 1'b0;
        force dut.count_bcd = pre_val;
        @(posedge clk);
        @(negedge clk);
        release dut.count_bcd;
        t = v;
        t_before = v;
        prev_s = 1'b0;
    endtask

    task automatic tick_to(input int target);
        while (t != target) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        slow_clk = 1'b1;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (count_bcd !== 24'h0) begin n_bad++; $display("FAIL reset_count: got %h want 000000", count_bcd); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an: got %b want 1111", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp); end
        reset_n = 1'b1;
        t = 0;
        prev_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            n_cmp++; if (count_bcd !== 24'h0) begin n_bad++; $display("FAIL no_tick_after_reset: got %h want 000000", count_bcd); end
            n_cmp++; if (an !== exp_an(cyc)) begin n_bad++; $display("FAIL first_scan_an: got %b want %b", an, exp_an(cyc)); end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_count_100();
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0);
            n_cmp++; if (count_bcd !== to_bcd(t)) begin n_bad++; $display("FAIL count_rise: got %h want %h", count_bcd, to_bcd(t)); end
            repeat ($urandom_range(0, 2)) begin
                step(1'b1, 1'b0);
                n_cmp++; if (count_bcd !== to_bcd(t)) begin n_bad++; $display("FAIL count_steady_high: got %h want %h", count_bcd, to_bcd(t)); end
            end
            repeat ($urandom_range(1, 3)) begin
                step(1'b0, 1'b0);
                n_cmp++; if (count_bcd !== to_bcd(t)) begin n_bad++; $display("FAIL count_low: got %h want %h", count_bcd, to_bcd(t)); end
            end
        end
        n_cmp++; if (count_bcd !== 24'h000100) begin n_bad++; $display("FAIL count_100: got %h want 000100", count_bcd); end
    endtask

    task automatic test_wrap();
        preload(5999);
        n_cmp++; if (count_bcd !== 24'h005999) begin n_bad++; $display("FAIL preload_5999: got %h want 005999", count_bcd); end
        step(1'b1, 1'b0);
        n_cmp++; if (count_bcd !== 24'h010000) begin n_bad++; $display("FAIL minute_carry: got %h want 010000", count_bcd); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL minute_carry_wrap: got %b want 0", wrap); end
        step(1'b0, 1'b0);
        preload(359990);
        n_cmp++; if (count_bcd !== 24'h595990) begin n_bad++; $display("FAIL preload_595990: got %h want 595990", count_bcd); end
        tick_to(359999);
        n_cmp++; if (count_bcd !== 24'h595999) begin n_bad++; $display("FAIL reach_595999: got %h want 595999", count_bcd); end
        step(1'b1, 1'b0);
        n_cmp++; if (count_bcd !== 24'h0) begin n_bad++; $display("FAIL wrap_count: got %h want 000000", count_bcd); end
        n_cmp++; if (wrap !== wrap_exp || wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_pulse: got %b want 1", wrap); end
        step(1'b1, 1'b0);
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_one_cycle: got %b want 0", wrap); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_clr_tick();
        step(1'b0, 1'b1);
        n_cmp++; if (count_bcd !== 24'h0) begin n_bad++; $display("FAIL clr_alone: got %h want 000000", count_bcd); end
        tick_to(42);
        n_cmp++; if (count_bcd !== 24'h000042) begin n_bad++; $display("FAIL reach_42: got %h want 000042", count_bcd); end
        step(1'b1, 1'b1);
        n_cmp++; if (count_bcd !== 24'h0) begin n_bad++; $display("FAIL clr_beats_tick: got %h want 000000", count_bcd); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL clr_wrap: got %b want 0", wrap); end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_cmp++; if (count_bcd !== 24'h000001) begin n_bad++; $display("FAIL tick_after_clr: got %h want 000001", count_bcd); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_scan(input int target, input string tag);
        tick_to(target);
        for (int k = 0; k < 4 * DIV * 2; k++) begin
            step(1'b0, 1'b0);
            n_cmp++; if (an !== exp_an(cyc)) begin n_bad++; $display("FAIL scan_an_%s: got %b want %b", tag, an, exp_an(cyc)); end
            n_cmp++; if (seg !== exp_seg(t_before, cyc)) begin n_bad++; $display("FAIL scan_seg_%s: got %b want %b", tag, seg, exp_seg(t_before, cyc)); end
            n_cmp++; if (dp !== (an != 4'b1011)) begin n_bad++; $display("FAIL scan_dp_%s: got %b with an %b", tag, dp, an); end
        end
    endtask

    task automatic test_random();
        preload(359800 + $urandom_range(0, 99));
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 255) == 0));
            n_cmp++; if (count_bcd !== to_bcd(t)) begin n_bad++; $display("FAIL rand_count: got %h want %h", count_bcd, to_bcd(t)); end
            n_cmp++; if (wrap !== wrap_exp) begin n_bad++; $display("FAIL rand_wrap: got %b want %b", wrap, wrap_exp); end
            n_cmp++; if (an !== exp_an(cyc)) begin n_bad++; $display("FAIL rand_an: got %b want %b", an, exp_an(cyc)); end
            n_cmp++; if (seg !== exp_seg(t_before, cyc)) begin n_bad++; $display("FAIL rand_seg: got %b want %b", seg, exp_seg(t_before, cyc)); end
            n_cmp++; if (dp !== (exp_idx(cyc) != 2)) begin n_bad++; $display("FAIL rand_dp: got %b want %b", dp, exp_idx(cyc) != 2); end
        end
    endtask

    initial begin
        test_reset();
        test_count_100();
        test_wrap();
        test_clr_tick();
        slow_clk = 1'b0;
        apply_reset();
        test_scan(1234, "secs");
        test_scan(6203, "mins");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
